// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer.
// FSM encodings, counter sizing and legal WIDTH range.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer_even_parity.sv
// Combinational even-parity reduction of one data word.
// Used by the serializer only when PISO_PARITY_EN is defined.
module even_parity #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  // XOR of all bits gives the even-parity bit
  always_comb begin
    parity = ^data;
  end

endmodule

// File: rtl/piso_serializer.sv
// MSB-first parallel-in/serial-out serializer with valid/ready load.
// Optional trailing even-parity bit: define PISO_PARITY_EN.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             d_out,
  output logic             d_valid,
  output logic             busy
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("piso_serializer: WIDTH out of range");
  end

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_bit;
  logic             hs;

  assign last_bit = (cnt_q == '0);
  assign hs       = load_valid && load_ready;

`ifdef PISO_PARITY_EN
  logic par_w;
  logic par_q;

  even_parity #(
    .WIDTH (WIDTH)
  ) u_par (
    .data   (load_data),
    .parity (par_w)
  );

  // Ready when idle or presenting the parity bit
  always_comb begin
    load_ready = !rst &&
      (state_q == IDLE || state_q == PARITY);
  end

  // Parity register captured alongside the data word
  always_ff @(posedge clk) begin
    if (rst)
      par_q <= 1'b0;
    else if (hs)
      par_q <= par_w;
  end
`else
  // Ready when idle or presenting the last data bit
  always_comb begin
    load_ready = !rst &&
      (state_q == IDLE ||
       (state_q == SHIFT && last_bit));
  end
`endif

  // Moore output decode from registered state
  always_comb begin
    d_out   = 1'b0;
    d_valid = 1'b0;
    case (state_q)
      SHIFT: begin
        d_out   = shreg_q[WIDTH-1];
        d_valid = 1'b1;
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        d_out   = par_q;
        d_valid = 1'b1;
      end
`endif
      default: begin
        d_out   = 1'b0;
        d_valid = 1'b0;
      end
    endcase
  end

  assign busy = (state_q != IDLE);

  // FSM, bit counter and shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs) begin
            shreg_q <= load_data;
            cnt_q   <= CNT_LAST;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (!last_bit) begin
            shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
            cnt_q   <= cnt_q - CNT_W'(1);
`ifdef PISO_PARITY_EN
          end else begin
            shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
            state_q <= PARITY;
          end
`else
          end else if (hs) begin
            shreg_q <= load_data;
            cnt_q   <= CNT_LAST;
            state_q <= SHIFT;
          end else begin
            shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
            state_q <= IDLE;
          end
`endif
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          if (hs) begin
            shreg_q <= load_data;
            cnt_q   <= CNT_LAST;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          shreg_q <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: queue-of-bits model plus
// literal stream checks for the directed scenarios.
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_data;
  logic         d_out;
  logic         d_valid;
  logic         busy;

  piso_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .d_out      (d_out),
    .d_valid    (d_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Model: bits still to be presented, front = current bit
  bit q[$];

  logic [63:0] seen_val;
  int          seen_n;
  int          runs;
  logic        prev_v;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  task automatic clear_seen();
    seen_val = '0;
    seen_n   = 0;
    runs     = 0;
    prev_v   = 1'b0;
  endtask

  task automatic push_word(input logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--) q.push_back(d[i]);
`ifdef PISO_PARITY_EN
    q.push_back(^d);
`endif
  endtask

  task automatic step(input logic r,
                      input logic v,
                      input logic [W-1:0] d);
    logic hs;
    logic ev;
    logic eo;
    logic er;
    @(negedge clk);
    rst        = r;
    load_valid = v;
    load_data  = d;
    #1;
    ev = (q.size() > 0);
    eo = ev ? q[0] : 1'b0;
    er = !r && (q.size() <= 1);
    check("d_valid", {63'd0, d_valid}, {63'd0, ev});
    check("d_out", {63'd0, d_out}, {63'd0, eo});
    check("busy", {63'd0, busy}, {63'd0, ev});
    check("load_ready", {63'd0, load_ready}, {63'd0, er});
    if (d_valid === 1'b1) begin
      seen_val = {seen_val[62:0], d_out};
      seen_n++;
      if (!prev_v) runs++;
    end
    prev_v = d_valid;
    hs = er && v;
    @(posedge clk);
    if (r) begin
      q.delete();
    end else begin
      if (q.size() > 0) void'(q.pop_front());
      if (hs) push_word(d);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  task automatic seen_check(input string name,
                            input int n,
                            input logic [63:0] v);
    check({name, "_len"}, 64'(seen_n), 64'(n));
    check({name, "_bits"}, seen_val, v);
  endtask

`ifdef PISO_PARITY_EN
  localparam logic [63:0] E66   = 64'({8'h66, 1'b0});
  localparam logic [63:0] EA53C =
    64'({8'hA5, 1'b0, 8'h3C, 1'b0});
  localparam logic [63:0] E81   = 64'({8'h81, 1'b0});
`else
  localparam logic [63:0] E66   = 64'h66;
  localparam logic [63:0] EA53C = 64'hA53C;
  localparam logic [63:0] E81   = 64'h81;
`endif

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    repeat (2) @(posedge clk);

    // Reset state and idle
    step(1'b1, 1'b0, '0);
    idle(5);

    // Single word
    clear_seen();
    step(1'b0, 1'b1, 8'h66);
    idle(NB + 3);
    seen_check("w66", NB, E66);
    check("w66_runs", 64'(runs), 64'd1);

    // Back-to-back words, continuous load_valid
    clear_seen();
    step(1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < NB; i++) step(1'b0, 1'b1, 8'h3C);
    idle(NB + 3);
    seen_check("b2b", 2 * NB, EA53C);
    check("b2b_runs", 64'(runs), 64'd1);

    // Reset mid-word
    clear_seen();
    step(1'b0, 1'b1, 8'hF0);
    idle(2);
    step(1'b1, 1'b0, '0);
    idle(3);
    seen_check("abort", 3, 64'h7);
    clear_seen();
    step(1'b0, 1'b1, 8'h81);
    idle(NB + 3);
    seen_check("w81", NB, E81);

    // Load attempt while busy is ignored
    clear_seen();
    step(1'b0, 1'b1, 8'h00);
    idle(3);
    step(1'b0, 1'b1, 8'hFF);
    idle(NB + 6);
    seen_check("ign", NB, 64'h0);

`ifdef PISO_PARITY_EN
    clear_seen();
    step(1'b0, 1'b1, 8'h07);
    idle(NB + 2);
    seen_check("p07", NB, 64'({8'h07, 1'b1}));
    clear_seen();
    step(1'b0, 1'b1, 8'h03);
    idle(NB + 2);
    seen_check("p03", NB, 64'({8'h03, 1'b0}));
`endif

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 59) == 0,
           $urandom_range(0, 3) != 0,
           W'($urandom));
    end
    idle(NB + 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
